// File: rtl/md_unit_if.sv
// md_unit_if: start/busy handshake, operand and HI/LO result bundle between execute-stage
// control and the multiply/divide unit.
//   start  request to execute op this cycle
//   op     operation code (0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MADDU)
//   A, B   operands rs/rt from the register-file read ports
//   busy   operation in flight; start is ignored
//   done   one-cycle pulse when HI/LO first carry a new multi-cycle result
//   HI, LO architectural HI/LO registers
// Modports: master = control side (drives start/op/A/B), slave = md_unit.
interface md_unit_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output start, op, A, B,
    input  busy, done, HI, LO
  );

  modport slave (
    input  start, op, A, B,
    output busy, done, HI, LO
  );
endinterface

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit owning the HI/LO registers.
// Ports:
//   clk    clock, rising edge
//   reset  asynchronous active-low reset
//   bus    md_unit_if.slave: start/op/A/B in; busy/done/HI/LO out (all register-driven)
// Parameters:
//   MULT_CYCLES  start-to-commit latency of MULT/MULTU (and MADD/MADDU), 1..31
//   DIV_CYCLES   start-to-commit latency of DIV/DIVU, 1..31
// Build option:
//   MDU_MADD_EN  when defined, op 6 (MADD) and op 7 (MADDU) accumulate A*B into {HI,LO};
//                otherwise ops 6/7 are no-ops.
// The result is computed at the accepting edge into res_hi/res_lo, so operands need not be
// held; the RUN phase only models the latency and HI/LO change at commit.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic       clk,
  input logic       reset,
  md_unit_if.slave  bus
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  localparam logic [4:0] MultLoad = 5'(MULT_CYCLES - 1);
  localparam logic [4:0] DivLoad  = 5'(DIV_CYCLES - 1);

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] res_hi_q, res_hi_d;
  logic [31:0] res_lo_q, res_lo_d;
  logic        done_q, done_d;

  // Products
  logic signed [63:0] a_sext, b_sext;
  logic [63:0]        prod_s, prod_u;

  assign a_sext = {{32{bus.A[31]}}, bus.A};
  assign b_sext = {{32{bus.B[31]}}, bus.B};
  assign prod_s = a_sext * b_sext;
  assign prod_u = {32'd0, bus.A} * {32'd0, bus.B};

`ifdef MDU_MADD_EN
  logic [63:0] acc_s, acc_u;
  assign acc_s = {hi_q, lo_q} + prod_s;
  assign acc_u = {hi_q, lo_q} + prod_u;
`endif

  // Quotients/remainders. Divide-by-zero and the signed overflow case are substituted with a
  // divisor of 1 so the divider never sees them; their results come from the mux below.
  logic        div_zero, div_ovf;
  logic [31:0] b_div;
  logic [31:0] q_s, r_s, q_u, r_u;
  logic [31:0] div_s_hi, div_s_lo, div_u_hi, div_u_lo;

  assign div_zero = (bus.B == 32'd0);
  assign div_ovf  = (bus.A == 32'h8000_0000) && (bus.B == 32'hFFFF_FFFF);
  assign b_div    = (div_zero || div_ovf) ? 32'd1 : bus.B;

  assign q_s = 32'($signed(bus.A) / $signed(b_div));
  assign r_s = 32'($signed(bus.A) % $signed(b_div));
  assign q_u = bus.A / b_div;
  assign r_u = bus.A % b_div;

  always_comb begin
    div_s_hi = r_s;
    div_s_lo = q_s;
    div_u_hi = r_u;
    div_u_lo = q_u;
    if (div_zero) begin
      div_s_hi = bus.A;
      div_s_lo = 32'hFFFF_FFFF;
      div_u_hi = bus.A;
      div_u_lo = 32'hFFFF_FFFF;
    end else if (div_ovf) begin
      div_s_hi = 32'd0;
      div_s_lo = 32'h8000_0000;
    end
  end

  // Next-state / outputs
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    done_d   = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          case (bus.op)
            3'd0: begin
              {res_hi_d, res_lo_d} = prod_s;
              cnt_d   = MultLoad;
              state_d = StRun;
            end
            3'd1: begin
              {res_hi_d, res_lo_d} = prod_u;
              cnt_d   = MultLoad;
              state_d = StRun;
            end
            3'd2: begin
              res_hi_d = div_s_hi;
              res_lo_d = div_s_lo;
              cnt_d    = DivLoad;
              state_d  = StRun;
            end
            3'd3: begin
              res_hi_d = div_u_hi;
              res_lo_d = div_u_lo;
              cnt_d    = DivLoad;
              state_d  = StRun;
            end
            3'd4: hi_d = bus.A;
            3'd5: lo_d = bus.A;
`ifdef MDU_MADD_EN
            3'd6: begin
              {res_hi_d, res_lo_d} = acc_s;
              cnt_d   = MultLoad;
              state_d = StRun;
            end
            3'd7: begin
              {res_hi_d, res_lo_d} = acc_u;
              cnt_d   = MultLoad;
              state_d = StRun;
            end
`endif
            default: ;
          endcase
        end
      end
      StRun: begin
        // start is ignored here; control holds the instruction until busy drops.
        if (cnt_q == 5'd0) begin
          hi_d    = res_hi_q;
          lo_d    = res_lo_q;
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= 5'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      res_hi_q <= 32'd0;
      res_lo_q <= 32'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy = (state_q == StRun);
  assign bus.done = done_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: expected {HI,LO} pushed to a scoreboard queue when an
// operation is issued, popped and compared when the unit commits.
module tb_md_unit;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  md_unit_if bus ();

  md_unit #(
    .MULT_CYCLES(MC),
    .DIV_CYCLES (DC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] sb_q[$];
  logic [31:0] exp_hi, exp_lo;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference arithmetic in 64-bit integers.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] hi,
                                        input logic [31:0] lo);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: p = sa * sb;
      3'd1: p = {32'd0, a} * {32'd0, b};
      3'd2: begin
        if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      3'd3: begin
        if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
        else p = {a % b, a / b};
      end
      3'd6: p = {hi, lo} + 64'(sa * sb);
      3'd7: p = {hi, lo} + {32'd0, a} * {32'd0, b};
      default: p = {hi, lo};
    endcase
    return p;
  endfunction

  // Issue a multi-cycle op at the current negedge and follow it to commit. With intrude set,
  // an MTHI is presented (and held) from RUN cycle 2 onward.
  task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input bit intrude);
    logic [63:0] e;
    int          cycles;
    e = model(op, a, b, exp_hi, exp_lo);
    sb_q.push_back(e);
    bus.start = 1'b1;
    bus.op    = op;
    bus.A     = a;
    bus.B     = b;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    check_eq("done_clear", 64'(bus.done), 64'd0);
    cycles = 0;
    while (!bus.done && cycles <= lat + 2) begin
      check_eq("busy_run", 64'(bus.busy), 64'd1);
      check_eq("hilo_hold", {bus.HI, bus.LO}, {exp_hi, exp_lo});
      cycles++;
      if (intrude && cycles == 2) begin
        bus.start = 1'b1;
        bus.op    = 3'd4;
        bus.A     = 32'h1234_5678;
      end
      @(negedge clk);
    end
    check_eq("done_seen", 64'(bus.done), 64'd1);
    check_eq("latency", 64'(cycles), 64'(lat));
    check_eq("busy_done", 64'(bus.busy), 64'd0);
    check_eq("sb_size", 64'(sb_q.size()), 64'd1);
    if (sb_q.size() > 0) check_eq("result", {bus.HI, bus.LO}, sb_q.pop_front());
    {exp_hi, exp_lo} = e;
  endtask

  task automatic run_mt(input logic [2:0] op, input logic [31:0] a);
    logic [63:0] e;
    e = (op == 3'd4) ? {a, exp_lo} : {exp_hi, a};
    sb_q.push_back(e);
    bus.start = 1'b1;
    bus.op    = op;
    bus.A     = a;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    check_eq("mt_busy", 64'(bus.busy), 64'd0);
    check_eq("mt_done", 64'(bus.done), 64'd0);
    check_eq("sb_size", 64'(sb_q.size()), 64'd1);
    if (sb_q.size() > 0) check_eq("mt_result", {bus.HI, bus.LO}, sb_q.pop_front());
    {exp_hi, exp_lo} = e;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    reset     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.A     = 32'd0;
    bus.B     = 32'd0;
    exp_hi    = 32'd0;
    exp_lo    = 32'd0;
    repeat (2) @(negedge clk);
    check_eq("rst_hi", 64'(bus.HI), 64'd0);
    check_eq("rst_lo", 64'(bus.LO), 64'd0);
    check_eq("rst_busy", 64'(bus.busy), 64'd0);
    check_eq("rst_done", 64'(bus.done), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // Directed cases, issued back-to-back on each done cycle.
    run_md(3'd0, 32'hFFFF_FFFF, 32'h0000_0002, MC, 1'b0);
    check_eq("mult_fixed", {bus.HI, bus.LO}, 64'hFFFF_FFFF_FFFF_FFFE);
    run_md(3'd1, 32'hFFFF_FFFF, 32'h0000_0002, MC, 1'b0);
    check_eq("multu_fixed", {bus.HI, bus.LO}, 64'h0000_0001_FFFF_FFFE);
    run_md(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, DC, 1'b0);
    check_eq("div_fixed", {bus.HI, bus.LO}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_md(3'd3, 32'd5, 32'd0, DC, 1'b0);
    check_eq("divu_zero", {bus.HI, bus.LO}, 64'h0000_0005_FFFF_FFFF);
    run_md(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, DC, 1'b0);
    check_eq("div_ovf", {bus.HI, bus.LO}, 64'h0000_0000_8000_0000);
    run_md(3'd2, 32'hFFFF_FFF7, 32'd0, DC, 1'b0);
    run_md(3'd2, 32'd7, 32'hFFFF_FFFE, DC, 1'b0);

    // MTHI held during RUN is ignored, then accepted once busy drops.
    run_md(3'd0, 32'd7, 32'd3, MC, 1'b1);
    run_mt(3'd4, 32'h1234_5678);
    check_eq("mthi_after", 64'(bus.HI), 64'h1234_5678);
    run_mt(3'd5, 32'hCAFE_F00D);

    for (int i = 0; i < 8; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      run_md(rop, ra, rb, (rop < 3'd2) ? int'(MC) : int'(DC), 1'b0);
    end

`ifdef MDU_MADD_EN
    run_mt(3'd4, 32'd0);
    run_mt(3'd5, 32'hFFFF_FFFF);
    run_md(3'd7, 32'd1, 32'd1, MC, 1'b0);
    check_eq("maddu_fixed", {bus.HI, bus.LO}, 64'h0000_0001_0000_0000);
    run_md(3'd6, 32'hFFFF_FFFF, 32'd3, MC, 1'b0);
`else
    // Ops 6/7 are no-ops without the accumulate option.
    for (int k = 6; k < 8; k++) begin
      bus.start = 1'b1;
      bus.op    = 3'(k);
      bus.A     = 32'h0BAD_0BAD;
      bus.B     = 32'd9;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      check_eq("noop_busy", 64'(bus.busy), 64'd0);
      check_eq("noop_done", 64'(bus.done), 64'd0);
      check_eq("noop_hilo", {bus.HI, bus.LO}, {exp_hi, exp_lo});
      @(negedge clk);
      check_eq("noop_busy2", 64'(bus.busy), 64'd0);
    end
`endif

    // Reset in RUN cycle 3 of a DIV discards the result.
    run_mt(3'd4, 32'hAAAA_5555);
    bus.start = 1'b1;
    bus.op    = 3'd2;
    bus.A     = 32'd100;
    bus.B     = 32'd7;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("arst_hi", 64'(bus.HI), 64'd0);
    check_eq("arst_lo", 64'(bus.LO), 64'd0);
    check_eq("arst_busy", 64'(bus.busy), 64'd0);
    check_eq("arst_done", 64'(bus.done), 64'd0);
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < int'(DC) + 3; c++) begin
      @(negedge clk);
      check_eq("post_rst_done", 64'(bus.done), 64'd0);
      check_eq("post_rst_busy", 64'(bus.busy), 64'd0);
    end
    check_eq("post_rst_hilo", {bus.HI, bus.LO}, 64'd0);

    run_md(3'd0, 32'd3, 32'hFFFF_FFFC, MC, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit that consumes the two register-file read operands (RD1/RD2) for MULT/MULTU/DIV/DIVU/MTHI/MTLO and owns the HI/LO architectural registers. It sits directly downstream of the register file, beside the ALU in the execute path. It runs multi-cycle operations behind a start/busy handshake so control can stall MFHI/MFLO and further MD instructions. HI/LO values read back via MFHI/MFLO return to the register file's write-data mux.

## Interface
- `MULT_CYCLES`, default 5: cycles from accepted start to result commit for MULT/MULTU (and MADD/MADDU when enabled); legal range 1-31.
- `DIV_CYCLES`, default 10: cycles from accepted start to result commit for DIV/DIVU; legal range 1-31.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  request to execute `op` this cycle.
- `op`  in  3  operation code: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MADDU.
- `A`  in  32  operand rs (from RD1).
- `B`  in  32  operand rt (from RD2).
- `busy`  out  1  operation in flight; no new start is accepted.
- `done`  out  1  one-cycle pulse on the cycle HI/LO shows a new multi-cycle result.
- `HI`  out  32  HI register, registered output.
- `LO`  out  32  LO register, registered output.

## Operation
- States: IDLE, RUN. A 5-bit down-counter is loaded on entry to RUN.
- IDLE with `start`=1:
  - op 4/5: write `A` to HI/LO at that edge and stay in IDLE. `busy` stays 0 and `done` stays 0.
  - op 0-3 (and 6/7 with the macro): latch `A`, `B` and `op`, compute the result into internal `res_hi`/`res_lo`, load the counter with MULT_CYCLES-1 or DIV_CYCLES-1, and go to RUN.
- RUN:
  - Counter decrements each edge.
  - At the edge where the counter is 0, commit `res_hi`/`res_lo` to HI/LO, assert `done` for the following cycle, and return to IDLE.
- `start` during RUN is ignored entirely, including MTHI/MTLO. Control must hold the instruction until `busy`=0.
- HI/LO keep their old values throughout RUN and change only at commit.
- Arithmetic:
  - MULT: signed 32x32 -> 64-bit product; {HI,LO} = product.
  - MULTU: unsigned 32x32 -> 64-bit product.
  - DIV: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - DIVU: unsigned quotient in LO, remainder in HI.
- Boundary cases:
  - Divide by zero (`B`=0): LO = 0xFFFFFFFF, HI = `A`, for both DIV and DIVU. Latency is still DIV_CYCLES.
  - DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0. No exception.
- Reset asserted (`reset`=0) at any time, including mid-RUN:
  - HI = 0, LO = 0, `busy` = 0, `done` = 0, state IDLE.
  - The in-flight result is discarded.
- Undefined op values (6/7 without the macro) are treated as no-ops in IDLE: no state change.

## Timing
- `busy` = 1 exactly while in RUN: from the edge that accepts `start` through the commit edge.
  - MULT: `busy` is high for MULT_CYCLES cycles.
  - DIV: `busy` is high for DIV_CYCLES cycles.
- Result latency: HI/LO are visible MULT_CYCLES/DIV_CYCLES cycles after the accepting edge.
- `done` is high in the first cycle HI/LO carry the new value, coincident with `busy` falling.
- MTHI/MTLO have 1-cycle latency: the new value is visible the cycle after the accepting edge.
- A new `start` is accepted in the same cycle `done`=1, giving back-to-back operation with no bubble.
- All outputs are register-driven. There are no combinational paths from inputs to outputs.

## Configuration
- `MDU_MADD_EN`
  - Defined: op 6 (MADD, signed) and op 7 (MADDU, unsigned) are supported. They compute {HI,LO} + A*B modulo 2^64 with MULT_CYCLES latency. The accumulation uses the {HI,LO} value held at the accepting edge.
  - Undefined: ops 6/7 are no-ops, no accumulator adder is instantiated, and the RTL contains no MADD logic.

## Test plan
- Reset, then MULT A=0xFFFFFFFF, B=0x00000002 with defaults -> `busy` high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE with `done` pulsed once.
- MULTU with same operands -> HI=0x00000001, LO=0xFFFFFFFE after 5 cycles.
- DIV A=0xFFFFFFF9 (-7), B=2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU A=5, B=0 -> LO=0xFFFFFFFF, HI=5.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI 0x12345678 issued during RUN is ignored, then accepted after `done`, giving HI=0x12345678 the next cycle.
- Drive `reset`=0 in RUN cycle 3 of a DIV -> HI=LO=0 and `busy`=0 immediately, and no `done` pulse.
- With `MDU_MADD_EN`: HI=0, LO=0xFFFFFFFF, MADDU A=1, B=1 -> HI=1, LO=0.
